// File: rtl/player_move_ctrl.sv
// Debounced two-key stepper for the red player's grid position with a redraw handshake.
// Optional build macro PLAYER_MOVE_WRAP_EN: steps off the last column/row wrap to 0 instead of being dropped.
module player_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_COLS       = 8,
  parameter int GRID_ROWS       = 8,
  parameter int INIT_X          = 1,
  parameter int INIT_Y          = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_x_n,
  input  logic       key_y_n,
  input  logic [3:0] other_x,
  input  logic [3:0] other_y,
  input  logic       redraw_ack,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       redraw_req,
  output logic       blocked
);

  localparam int         CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_X   = 4'(GRID_COLS - 1);
  localparam logic [3:0] MAX_Y   = 4'(GRID_ROWS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  // Index 0 is the X key, index 1 the Y key.
  logic [1:0]    keys_s;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    acc_q, acc_d;
  logic [1:0]    press_q, press_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    clr_s;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t     state_q, state_d;
  logic [3:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic       req_q, req_d, blocked_q, blocked_d;
  logic [3:0] cand_x_s, cand_y_s;
  logic       step_ok_s;

  assign keys_s = {key_y_n, key_x_n};

  // Debounce: count while the synchronized level disagrees, flip and flag a press on 1->0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]   = cnt_q[i];
      acc_d[i]   = acc_q[i];
      press_d[i] = 1'b0;
      if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]   = {CW{1'b0}};
        acc_d[i]   = ~acc_q[i];
        press_d[i] = acc_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      pend_d[i] = (pend_q[i] & ~clr_s[i]) | press_q[i];
    end
  end

  // Move FSM: X has priority; steps are edge-checked, collision-checked, then handed off.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    req_d     = req_q;
    blocked_d = 1'b0;
    clr_s     = 2'b00;
    cand_x_s  = pos_x_q;
    cand_y_s  = pos_y_q;
    step_ok_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q[0]) begin
          clr_s[0] = 1'b1;
`ifdef PLAYER_MOVE_WRAP_EN
          cand_x_s  = (pos_x_q == MAX_X) ? 4'd0 : pos_x_q + 4'd1;
          step_ok_s = 1'b1;
`else
          cand_x_s  = pos_x_q + 4'd1;
          step_ok_s = (pos_x_q != MAX_X);
`endif
        end else if (pend_q[1]) begin
          clr_s[1] = 1'b1;
`ifdef PLAYER_MOVE_WRAP_EN
          cand_y_s  = (pos_y_q == MAX_Y) ? 4'd0 : pos_y_q + 4'd1;
          step_ok_s = 1'b1;
`else
          cand_y_s  = pos_y_q + 4'd1;
          step_ok_s = (pos_y_q != MAX_Y);
`endif
        end else begin
          step_ok_s = 1'b0;
        end
        if (step_ok_s) begin
          if ((cand_x_s == other_x) && (cand_y_s == other_y)) begin
            blocked_d = 1'b1;
          end else begin
            pos_x_d = cand_x_s;
            pos_y_d = cand_y_s;
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (redraw_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset returns keys to released and discards pending steps.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      acc_q     <= 2'b11;
      press_q   <= 2'b00;
      pend_q    <= 2'b00;
      cnt_q[0]  <= {CW{1'b0}};
      cnt_q[1]  <= {CW{1'b0}};
      state_q   <= IDLE;
      pos_x_q   <= 4'(INIT_X);
      pos_y_q   <= 4'(INIT_Y);
      req_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      sync1_q   <= keys_s;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      press_q   <= press_d;
      pend_q    <= pend_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      req_q     <= req_d;
      blocked_q <= blocked_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign redraw_req = req_q;
  assign blocked    = blocked_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with DEBOUNCE_CYCLES=4; outputs sampled 1 time unit after each rising edge.
module tb_player_move_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       key_x_n = 1'b1;
  logic       key_y_n = 1'b1;
  logic [3:0] other_x = 4'd15;
  logic [3:0] other_y = 4'd15;
  logic       redraw_ack = 1'b0;
  logic [3:0] pos_x, pos_y;
  logic       redraw_req, blocked;

  int errors = 0;
  int checks = 0;

  player_move_ctrl #(
    .DEBOUNCE_CYCLES(4), .GRID_COLS(8), .GRID_ROWS(8), .INIT_X(1), .INIT_Y(1)
  ) dut (
    .clock(clock), .resetn(resetn), .key_x_n(key_x_n), .key_y_n(key_y_n),
    .other_x(other_x), .other_y(other_y), .redraw_ack(redraw_ack),
    .pos_x(pos_x), .pos_y(pos_y), .redraw_req(redraw_req), .blocked(blocked)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    key_x_n = 1'b1; key_y_n = 1'b1; redraw_ack = 1'b0;
    other_x = 4'd15; other_y = 4'd15;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic pulse_ack();
    redraw_ack = 1'b1;
    tick(1);
    redraw_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pos_x !== 4'd1) begin errors++; $display("FAIL reset_pos_x: got %0d expected 1", pos_x); end
    checks++; if (pos_y !== 4'd1) begin errors++; $display("FAIL reset_pos_y: got %0d expected 1", pos_y); end
    checks++; if (redraw_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", redraw_req); end
    checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL reset_blocked: got %b expected 0", blocked); end
  endtask

  task automatic test_press_latency();
    do_reset();
    key_x_n = 1'b0;
    tick(7);
    checks++; if (pos_x !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL latency_early: got pos_x=%0d req=%b expected 1/0", pos_x, redraw_req); end
    tick(1);
    checks++; if (pos_x !== 4'd2 || pos_y !== 4'd1) begin errors++; $display("FAIL latency_pos: got (%0d,%0d) expected (2,1)", pos_x, pos_y); end
    checks++; if (redraw_req !== 1'b1) begin errors++; $display("FAIL latency_req: got %b expected 1", redraw_req); end
    key_x_n = 1'b1;
    tick(8);
    checks++; if (redraw_req !== 1'b1 || pos_x !== 4'd2) begin errors++; $display("FAIL hold_wait_ack: got req=%b pos_x=%0d expected 1/2", redraw_req, pos_x); end
    pulse_ack();
    checks++; if (redraw_req !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", redraw_req); end
  endtask

  task automatic test_bounce();
    do_reset();
    key_y_n = 1'b0;
    tick(3);
    key_y_n = 1'b1;
    tick(12);
    checks++; if (pos_y !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL bounce: got pos_y=%0d req=%b expected 1/0", pos_y, redraw_req); end
  endtask

  task automatic test_collision();
    do_reset();
    other_x = 4'd2; other_y = 4'd1;
    key_x_n = 1'b0;
    tick(8);
    checks++; if (blocked !== 1'b1) begin errors++; $display("FAIL blocked_pulse: got %b expected 1", blocked); end
    checks++; if (pos_x !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL blocked_pos: got pos_x=%0d req=%b expected 1/0", pos_x, redraw_req); end
    tick(1);
    checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL blocked_once: got %b expected 0", blocked); end
    key_x_n = 1'b1;
    tick(8);
    checks++; if (pos_x !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL blocked_after: got pos_x=%0d req=%b expected 1/0", pos_x, redraw_req); end
    other_x = 4'd15; other_y = 4'd15;
  endtask

  task automatic test_back_to_back();
    do_reset();
    key_x_n = 1'b0; key_y_n = 1'b0;
    tick(8);
    checks++; if (pos_x !== 4'd2 || pos_y !== 4'd1 || redraw_req !== 1'b1) begin errors++; $display("FAIL b2b_first: got (%0d,%0d) req=%b expected (2,1) 1", pos_x, pos_y, redraw_req); end
    key_x_n = 1'b1; key_y_n = 1'b1;
    pulse_ack();
    checks++; if (redraw_req !== 1'b0 || pos_y !== 4'd1) begin errors++; $display("FAIL b2b_ack: got req=%b pos_y=%0d expected 0/1", redraw_req, pos_y); end
    tick(1);
    checks++; if (pos_x !== 4'd2 || pos_y !== 4'd2 || redraw_req !== 1'b1) begin errors++; $display("FAIL b2b_second: got (%0d,%0d) req=%b expected (2,2) 1", pos_x, pos_y, redraw_req); end
    tick(8);
    pulse_ack();
    tick(6);
    checks++; if (pos_x !== 4'd2 || pos_y !== 4'd2 || redraw_req !== 1'b0) begin errors++; $display("FAIL b2b_settle: got (%0d,%0d) req=%b expected (2,2) 0", pos_x, pos_y, redraw_req); end
  endtask

  task automatic test_edge();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      key_x_n = 1'b0;
      tick(8);
      key_x_n = 1'b1;
      tick(8);
      pulse_ack();
    end
    checks++; if (pos_x !== 4'd7 || redraw_req !== 1'b0) begin errors++; $display("FAIL edge_setup: got pos_x=%0d req=%b expected 7/0", pos_x, redraw_req); end
    key_x_n = 1'b0;
    tick(8);
`ifdef PLAYER_MOVE_WRAP_EN
    checks++; if (pos_x !== 4'd0 || redraw_req !== 1'b1) begin errors++; $display("FAIL edge_wrap: got pos_x=%0d req=%b expected 0/1", pos_x, redraw_req); end
`else
    checks++; if (pos_x !== 4'd7 || redraw_req !== 1'b0 || blocked !== 1'b0) begin errors++; $display("FAIL edge_drop: got pos_x=%0d req=%b blk=%b expected 7/0/0", pos_x, redraw_req, blocked); end
`endif
    key_x_n = 1'b1;
    tick(8);
    pulse_ack();
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    key_x_n = 1'b0;
    tick(8);
    key_x_n = 1'b1;
    key_y_n = 1'b0;
    tick(8);
    checks++; if (redraw_req !== 1'b1 || pos_x !== 4'd2 || pos_y !== 4'd1) begin errors++; $display("FAIL mid_setup: got (%0d,%0d) req=%b expected (2,1) 1", pos_x, pos_y, redraw_req); end
    key_y_n = 1'b1;
    resetn = 1'b0;
    #2;
    checks++; if (pos_x !== 4'd1 || pos_y !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL mid_async: got (%0d,%0d) req=%b expected (1,1) 0", pos_x, pos_y, redraw_req); end
    tick(2);
    resetn = 1'b1;
    redraw_ack = 1'b1;
    tick(2);
    redraw_ack = 1'b0;
    tick(20);
    checks++; if (pos_x !== 4'd1 || pos_y !== 4'd1 || redraw_req !== 1'b0) begin errors++; $display("FAIL mid_no_move: got (%0d,%0d) req=%b expected (1,1) 0", pos_x, pos_y, redraw_req); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_collision();
    test_back_to_back();
    test_edge();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
